// File: rtl/edge_event_arbiter.sv
// Per-channel edge detection with mode qualification, one-deep pending slot per channel,
// and round-robin sharing of pending events onto a single valid/ready event port.
module edge_event_arbiter #(
  parameter int N_CH  = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  sig_in,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_ch,
  input  logic [1:0]       cfg_mode,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_ch,
  output logic             evt_rise,
  output logic             evt_ovf,
  output logic [N_CH-1:0]  pending
);

  logic [N_CH-1:0]  r_prev;
  logic [1:0]       r_mode [N_CH];
  logic [N_CH-1:0]  r_pending;
  logic [N_CH-1:0]  r_ptype;
  logic [N_CH-1:0]  r_lost;
  logic [IDX_W-1:0] r_ptr;
  logic             r_evt_valid;
  logic [IDX_W-1:0] r_evt_ch;
  logic             r_evt_rise;
  logic             r_evt_ovf;

  logic [N_CH-1:0]  w_rise;
  logic [N_CH-1:0]  w_fall;
  logic [N_CH-1:0]  w_det;
  logic             w_found;
  logic [IDX_W-1:0] w_winner;
  logic             w_slot_free;
  logic             w_load;
  logic [N_CH-1:0]  w_grant;

  always_comb begin
    w_rise = '0;
    w_fall = '0;
    w_det  = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_rise[i] = sig_in[i] & ~r_prev[i];
      w_fall[i] = ~sig_in[i] & r_prev[i];
      w_det[i]  = (w_rise[i] & r_mode[i][0]) | (w_fall[i] & r_mode[i][1]);
    end
  end

  // Search starts just after the last winner, wrapping modulo N_CH.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= N_CH; k++) begin
      if (!w_found && r_pending[(int'(r_ptr) + k) % N_CH]) begin
        w_found  = 1'b1;
        w_winner = IDX_W'((int'(r_ptr) + k) % N_CH);
      end
    end
  end

  assign w_slot_free = !r_evt_valid || evt_ready;
  assign w_load      = w_slot_free && w_found;

  always_comb begin
    w_grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_grant[i] = w_load && (w_winner == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev      <= '0;
      r_pending   <= '0;
      r_ptype     <= '0;
      r_lost      <= '0;
      r_ptr       <= IDX_W'(N_CH - 1);
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
      r_evt_rise  <= 1'b0;
      r_evt_ovf   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_mode[i] <= 2'b00;
      end
    end else begin
      r_prev <= sig_in;

      for (int i = 0; i < N_CH; i++) begin
        if (cfg_we && cfg_ch == IDX_W'(i)) begin
          r_mode[i] <= cfg_mode;
        end
      end

      // A granted channel hands its event to the output stage; a coincident edge refills it.
      for (int i = 0; i < N_CH; i++) begin
        if (w_det[i]) begin
          if (w_grant[i]) begin
            r_ptype[i] <= w_rise[i];
            r_lost[i]  <= 1'b0;
          end else if (r_pending[i]) begin
            r_lost[i] <= 1'b1;
          end else begin
            r_pending[i] <= 1'b1;
            r_ptype[i]   <= w_rise[i];
          end
        end else if (w_grant[i]) begin
          r_pending[i] <= 1'b0;
          r_lost[i]    <= 1'b0;
        end
      end

      if (w_load) begin
        r_evt_valid <= 1'b1;
        r_evt_ch    <= w_winner;
        r_evt_rise  <= |(r_ptype & w_grant);
        r_evt_ovf   <= |(r_lost & w_grant);
        r_ptr       <= w_winner;
      end else if (w_slot_free) begin
        r_evt_valid <= 1'b0;
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_ch    = r_evt_ch;
  assign evt_rise  = r_evt_rise;
  assign evt_ovf   = r_evt_ovf;
  assign pending   = r_pending;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: table of per-cycle vectors plus hand-written
// backpressure, overflow and asynchronous-reset sequences.
module tb_edge_event_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] sig_in;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_rise;
  logic       evt_ovf;
  logic [3:0] pending;

  int checks;
  int failures;

  edge_event_arbiter #(.N_CH(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .evt_ovf   (evt_ovf),
    .pending   (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] sig;
    logic       we;
    logic [1:0] ch;
    logic [1:0] mode;
    logic       rdy;
    logic       ev;
    logic [1:0] ech;
    logic       er;
    logic       eo;
    logic [3:0] ep;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic [3:0] sig, logic we, logic [1:0] ch, logic [1:0] mode,
                               logic rdy, logic ev, logic [1:0] ech, logic er, logic eo,
                               logic [3:0] ep);
    vec_t v;
    v.sig = sig; v.we = we; v.ch = ch; v.mode = mode; v.rdy = rdy;
    v.ev = ev; v.ech = ech; v.er = er; v.eo = eo; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock once, then compare the registered outputs.
  task automatic step(input logic [3:0] s, input logic we, input logic [1:0] ch,
                      input logic [1:0] md, input logic rdy, input logic ev,
                      input logic [1:0] ech, input logic er, input logic eo,
                      input logic [3:0] ep, input string tag);
    sig_in    = s;
    cfg_we    = we;
    cfg_ch    = ch;
    cfg_mode  = md;
    evt_ready = rdy;
    @(posedge clk);
    #1;
    chk({tag, " valid"}, 32'(evt_valid), 32'(ev));
    chk({tag, " pending"}, 32'(pending), 32'(ep));
    if (ev) begin
      chk({tag, " ch"}, 32'(evt_ch), 32'(ech));
      chk({tag, " rise"}, 32'(evt_rise), 32'(er));
      chk({tag, " ovf"}, 32'(evt_ovf), 32'(eo));
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    sig_in    = 4'b0000;
    cfg_we    = 1'b0;
    cfg_ch    = 2'd0;
    cfg_mode  = 2'b00;
    evt_ready = 1'b1;

    // Round-robin: all channels rising, two bursts, each starting from ch0.
    tbl.push_back(mkv(4'b0000, 1, 2'd0, 2'b01, 1, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b0000, 1, 2'd1, 2'b01, 1, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b0000, 1, 2'd2, 2'b01, 1, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b0000, 1, 2'd3, 2'b01, 1, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b1111, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b1111));
    tbl.push_back(mkv(4'b1111, 0, 2'd0, 2'b00, 1, 1, 2'd0, 1, 0, 4'b1110));
    tbl.push_back(mkv(4'b1111, 0, 2'd0, 2'b00, 1, 1, 2'd1, 1, 0, 4'b1100));
    tbl.push_back(mkv(4'b1111, 0, 2'd0, 2'b00, 1, 1, 2'd2, 1, 0, 4'b1000));
    tbl.push_back(mkv(4'b1111, 0, 2'd0, 2'b00, 1, 1, 2'd3, 1, 0, 4'b0000));
    tbl.push_back(mkv(4'b1111, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b0000, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b1111, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b1111));
    tbl.push_back(mkv(4'b1111, 0, 2'd0, 2'b00, 1, 1, 2'd0, 1, 0, 4'b1110));
    tbl.push_back(mkv(4'b1111, 0, 2'd0, 2'b00, 1, 1, 2'd1, 1, 0, 4'b1100));
    tbl.push_back(mkv(4'b1111, 0, 2'd0, 2'b00, 1, 1, 2'd2, 1, 0, 4'b1000));
    tbl.push_back(mkv(4'b1111, 0, 2'd0, 2'b00, 1, 1, 2'd3, 1, 0, 4'b0000));
    tbl.push_back(mkv(4'b1111, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b0000));
    // Single rise on ch0: two-cycle latency, valid for exactly one cycle.
    tbl.push_back(mkv(4'b0000, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b0001, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b0001));
    tbl.push_back(mkv(4'b0001, 0, 2'd0, 2'b00, 1, 1, 2'd0, 1, 0, 4'b0000));
    tbl.push_back(mkv(4'b0001, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b0000));
    // Mode filtering on ch1: falling only, then both edges.
    tbl.push_back(mkv(4'b0001, 1, 2'd1, 2'b10, 1, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b0011, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b0011, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b0011, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b0001, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b0010));
    tbl.push_back(mkv(4'b0001, 0, 2'd0, 2'b00, 1, 1, 2'd1, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b0001, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b0001, 1, 2'd1, 2'b11, 1, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b0011, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b0010));
    tbl.push_back(mkv(4'b0011, 0, 2'd0, 2'b00, 1, 1, 2'd1, 1, 0, 4'b0000));
    tbl.push_back(mkv(4'b0011, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b0001, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b0010));
    tbl.push_back(mkv(4'b0001, 0, 2'd0, 2'b00, 1, 1, 2'd1, 0, 0, 4'b0000));
    tbl.push_back(mkv(4'b0001, 0, 2'd0, 2'b00, 1, 0, 0, 0, 0, 4'b0000));

    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", 32'(evt_valid), 32'd0);
    chk("reset ch", 32'(evt_ch), 32'd0);
    chk("reset rise", 32'(evt_rise), 32'd0);
    chk("reset ovf", 32'(evt_ovf), 32'd0);
    chk("reset pending", 32'(pending), 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].sig, tbl[i].we, tbl[i].ch, tbl[i].mode, tbl[i].rdy,
           tbl[i].ev, tbl[i].ech, tbl[i].er, tbl[i].eo, tbl[i].ep, $sformatf("vec%0d", i));
    end

    // Backpressure on ch2 (both edges): held output, oldest event kept, lost flag set.
    step(4'b0001, 1, 2'd2, 2'b11, 0, 0, 2'd0, 0, 0, 4'b0000, "bp0");
    step(4'b0101, 0, 2'd0, 2'b00, 0, 0, 2'd0, 0, 0, 4'b0100, "bp1");
    step(4'b0001, 0, 2'd0, 2'b00, 0, 1, 2'd2, 1, 0, 4'b0100, "bp2");
    step(4'b0101, 0, 2'd0, 2'b00, 0, 1, 2'd2, 1, 0, 4'b0100, "bp3");
    step(4'b0101, 0, 2'd0, 2'b00, 0, 1, 2'd2, 1, 0, 4'b0100, "bp4");
    step(4'b0101, 0, 2'd0, 2'b00, 1, 1, 2'd2, 0, 1, 4'b0000, "bp5");
    step(4'b0101, 0, 2'd0, 2'b00, 1, 0, 2'd0, 0, 0, 4'b0000, "bp6");

    // An edge coinciding with the grant of ch2 replaces the pending event and clears lost.
    step(4'b0001, 0, 2'd0, 2'b00, 0, 0, 2'd0, 0, 0, 4'b0100, "rep1");
    step(4'b0101, 0, 2'd0, 2'b00, 0, 1, 2'd2, 0, 0, 4'b0100, "rep2");
    step(4'b0001, 0, 2'd0, 2'b00, 0, 1, 2'd2, 0, 0, 4'b0100, "rep3");
    step(4'b0101, 0, 2'd0, 2'b00, 1, 1, 2'd2, 1, 1, 4'b0100, "rep4");
    step(4'b0101, 0, 2'd0, 2'b00, 1, 1, 2'd2, 1, 0, 4'b0000, "rep5");
    step(4'b0101, 0, 2'd0, 2'b00, 1, 0, 2'd0, 0, 0, 4'b0000, "rep6");

    // Build evt_valid=1 on ch1 with pending=1010 and the pointer left at ch1.
    step(4'b0101, 1, 2'd3, 2'b00, 0, 0, 2'd0, 0, 0, 4'b0000, "rm0");
    step(4'b1111, 0, 2'd0, 2'b00, 0, 0, 2'd0, 0, 0, 4'b0010, "rm1");
    step(4'b1111, 0, 2'd0, 2'b00, 0, 1, 2'd1, 1, 0, 4'b0000, "rm2");
    step(4'b1111, 1, 2'd3, 2'b11, 0, 1, 2'd1, 1, 0, 4'b0000, "rm3");
    step(4'b0101, 0, 2'd0, 2'b00, 0, 1, 2'd1, 1, 0, 4'b1010, "rm4");

    #2;
    rst = 1'b1;
    #1;
    chk("async rst valid", 32'(evt_valid), 32'd0);
    chk("async rst ch", 32'(evt_ch), 32'd0);
    chk("async rst rise", 32'(evt_rise), 32'd0);
    chk("async rst ovf", 32'(evt_ovf), 32'd0);
    chk("async rst pending", 32'(pending), 32'd0);
    sig_in = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Modes cleared: no events until rewritten; then pointer restarts at ch0 priority.
    step(4'b1111, 0, 2'd0, 2'b00, 1, 0, 2'd0, 0, 0, 4'b0000, "post1");
    step(4'b0000, 0, 2'd0, 2'b00, 1, 0, 2'd0, 0, 0, 4'b0000, "post2");
    step(4'b1010, 0, 2'd0, 2'b00, 1, 0, 2'd0, 0, 0, 4'b0000, "post3");
    step(4'b0000, 1, 2'd1, 2'b01, 1, 0, 2'd0, 0, 0, 4'b0000, "post4");
    step(4'b0000, 1, 2'd3, 2'b01, 1, 0, 2'd0, 0, 0, 4'b0000, "post5");
    step(4'b1010, 0, 2'd0, 2'b00, 1, 0, 2'd0, 0, 0, 4'b1010, "post6");
    step(4'b1010, 0, 2'd0, 2'b00, 1, 1, 2'd1, 1, 0, 4'b1000, "post7");
    step(4'b1010, 0, 2'd0, 2'b00, 1, 1, 2'd3, 1, 0, 4'b0000, "post8");
    step(4'b1010, 0, 2'd0, 2'b00, 1, 0, 2'd0, 0, 0, 4'b0000, "post9");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
